// File: rtl/dag_gen.sv
// Data address generator: eight I/M/L/B register sets producing pre/post-modify
// addresses with circular buffering, plus a ureg read/write port to bus connect.
module dag_gen #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ps_dg_en,
  input  logic          ps_dg_dgsclt,
  input  logic          ps_dg_mdfy,
  input  logic [2:0]    ps_dg_iadd,
  input  logic [2:0]    ps_dg_madd,
  input  logic          ps_dg_wrt_en,
  input  logic [4:0]    ps_dg_wrt_add,
  input  logic [4:0]    ps_dg_rd_add,
  input  logic [DW-1:0] bc_dt,
  output logic [DW-1:0] dg_ps_add,
  output logic [DW-1:0] dg_dm_add,
  output logic [DW-1:0] dg_bc_dt
);

  localparam logic [1:0] GRP_I = 2'b00;
  localparam logic [1:0] GRP_M = 2'b01;
  localparam logic [1:0] GRP_L = 2'b10;
  localparam logic [1:0] GRP_B = 2'b11;

  logic [DW-1:0] i_reg [8];
  logic [DW-1:0] m_reg [8];
  logic [DW-1:0] l_reg [8];
  logic [DW-1:0] b_reg [8];

  logic [1:0] wr_grp, rd_grp;
  logic [2:0] wr_idx, rd_idx;

  assign wr_grp = ps_dg_wrt_add[4:3];
  assign wr_idx = ps_dg_wrt_add[2:0];
  assign rd_grp = ps_dg_rd_add[4:3];
  assign rd_idx = ps_dg_rd_add[2:0];

  // A B write also loads I of the same index, so it forwards into the I operand too.
  logic wr_i_hit, wr_m_hit, wr_l_hit, wr_b_hit;

  assign wr_i_hit = ps_dg_wrt_en && (wr_grp == GRP_I || wr_grp == GRP_B) && wr_idx == ps_dg_iadd;
  assign wr_m_hit = ps_dg_wrt_en && wr_grp == GRP_M && wr_idx == ps_dg_madd;
  assign wr_l_hit = ps_dg_wrt_en && wr_grp == GRP_L && wr_idx == ps_dg_iadd;
  assign wr_b_hit = ps_dg_wrt_en && wr_grp == GRP_B && wr_idx == ps_dg_iadd;

  logic [DW-1:0] op_i, op_m, op_l, op_b;

  assign op_i = wr_i_hit ? bc_dt : i_reg[ps_dg_iadd];
  assign op_m = wr_m_hit ? bc_dt : m_reg[ps_dg_madd];
  assign op_l = wr_l_hit ? bc_dt : l_reg[ps_dg_iadd];
  assign op_b = wr_b_hit ? bc_dt : b_reg[ps_dg_iadd];

  logic [DW:0]        sum_u, bound;
  logic signed [DW:0] sum_s;
  logic [DW-1:0]      next_i, addr;

  assign sum_u = {1'b0, op_i} + {1'b0, op_m};
  assign bound = {1'b0, op_b} + {1'b0, op_l};
  assign sum_s = $signed({1'b0, op_i}) + $signed({op_m[DW-1], op_m});

  // Low DW bits of the signed and unsigned sums agree, so wrap arithmetic uses sum_u.
  always_comb begin
    next_i = sum_u[DW-1:0];
    if (op_l != '0) begin
      if (!op_m[DW-1]) begin
        if (sum_u >= bound) next_i = sum_u[DW-1:0] - op_l;
      end else if (sum_s < $signed({1'b0, op_b})) begin
        next_i = sum_u[DW-1:0] + op_l;
      end
    end
  end

  assign addr      = ps_dg_mdfy ? sum_u[DW-1:0] : op_i;
  assign dg_ps_add = (ps_dg_en &&  ps_dg_dgsclt) ? addr : '0;
  assign dg_dm_add = (ps_dg_en && !ps_dg_dgsclt) ? addr : '0;

  logic          rd_fwd;
  logic [DW-1:0] rd_val;

  assign rd_fwd = ps_dg_wrt_en &&
                  (ps_dg_wrt_add == ps_dg_rd_add ||
                   (rd_grp == GRP_I && wr_grp == GRP_B && wr_idx == rd_idx));

  always_comb begin
    rd_val = '0;
    case (rd_grp)
      GRP_I:   rd_val = i_reg[rd_idx];
      GRP_M:   rd_val = m_reg[rd_idx];
      GRP_L:   rd_val = l_reg[rd_idx];
      default: rd_val = b_reg[rd_idx];
    endcase
  end

  assign dg_bc_dt = rd_fwd ? bc_dt : rd_val;

  // Later assignments win: ureg writes override the post-modify update on the same I.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 8; k++) begin
        i_reg[k] <= '0;
        m_reg[k] <= '0;
        l_reg[k] <= '0;
        b_reg[k] <= '0;
      end
    end else begin
      if (ps_dg_en && !ps_dg_mdfy) i_reg[ps_dg_iadd] <= next_i;
      if (ps_dg_wrt_en) begin
        case (wr_grp)
          GRP_I: i_reg[wr_idx] <= bc_dt;
          GRP_M: m_reg[wr_idx] <= bc_dt;
          GRP_L: l_reg[wr_idx] <= bc_dt;
          default: begin
            b_reg[wr_idx] <= bc_dt;
            i_reg[wr_idx] <= bc_dt;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/dag_gen.md
DAG_GEN -- requirements
Module: dag_gen

Interface
REQ-001 Parameter: DW, 16, address/data width; all I/M/L/B registers, bc_dt and outputs are DW bits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 ps_dg_en  in  1  address-generation request this cycle.
REQ-005 ps_dg_dgsclt  in  1  destination: 1 = sequencer (dg_ps_add), 0 = data memory (dg_dm_add).
REQ-006 ps_dg_mdfy  in  1  1 = pre-modify (no I update), 0 = post-modify (I updated).
REQ-007 ps_dg_iadd  in  3  I register index.
REQ-008 ps_dg_madd  in  3  M register index.
REQ-009 ps_dg_wrt_en  in  1  ureg write strobe.
REQ-010 ps_dg_wrt_add  in  5  ureg write address: [4:3] group (00 I, 01 M, 10 L, 11 B), [2:0] index.
REQ-011 ps_dg_rd_add  in  5  ureg read address, same encoding.
REQ-012 bc_dt  in  DW  ureg write data from bus connect.
REQ-013 dg_ps_add  out  DW  jump/call target to sequencer.
REQ-014 dg_dm_add  out  DW  data memory address.
REQ-015 dg_bc_dt  out  DW  ureg read data to bus connect.

Function
REQ-016 State: four banks I0-7, M0-7, L0-7, B0-7, DW bits each; M is two's-complement signed, I/L/B unsigned.
REQ-017 Effective operands: I = I[iadd], M = M[madd], L = L[iadd], B = B[iadd], each forwarded from bc_dt when ps_dg_wrt_en and ps_dg_wrt_add addresses that register in the same cycle.
REQ-018 Outputs are combinational within the request cycle; register updates occur on the next rising edge.
REQ-019 Pre-modify (mdfy=1): address = (I+M) mod 2^DW; no register changes.
REQ-020 Post-modify (mdfy=0): address = I; I[iadd] <= next_I at the clock edge.
REQ-021 next_I when L=0: (I+M) mod 2^DW.
REQ-022 next_I when L!=0, M>=0: S=I+M computed at DW+1 bits; if S >= B+L (DW+1 bits) then S-L, else S; truncated to DW.
REQ-023 next_I when L!=0, M<0: S=I+M (signed, DW+1 bits); if S < B then S+L, else S; truncated to DW.
REQ-024 dg_ps_add = address when ps_dg_en & dgsclt, else 0.
REQ-025 dg_dm_add = address when ps_dg_en & !dgsclt, else 0.
REQ-026 ps_dg_en=0: no register modification other than ureg writes.
REQ-027 Ureg write: selected register <= bc_dt at the edge when ps_dg_wrt_en=1.
REQ-028 B write also loads I of the same index with bc_dt at the same edge.
REQ-029 Priority on the same I register in one edge: explicit I write > B-write side-load > post-modify update.
REQ-030 Ureg writes to M/L/B never block a concurrent post-modify of a different register; all applicable updates take effect together.
REQ-031 dg_bc_dt = register at ps_dg_rd_add; bc_dt instead when ps_dg_wrt_en and ps_dg_wrt_add==ps_dg_rd_add; for a read of I[k] concurrent with a B[k] write, bc_dt.
REQ-032 dg_bc_dt reflects post-modify updates only from the cycle after the edge.

Reset
REQ-033 rst low: all I/M/L/B cleared to 0 immediately, independent of clk; dg_ps_add, dg_dm_add, dg_bc_dt = 0 while ps_dg_en=0 and wrt_en=0.
REQ-034 Reset asserted mid-request: pending post-modify and ureg writes discarded; first edge after release performs normal operation.

Verification
REQ-035 Write I2=0x0100, M3=0x0004; request en=1, dgsclt=0, mdfy=0, iadd=2, madd=3 -> dg_dm_add=0x0100 that cycle, I2 reads 0x0104 next cycle.
REQ-036 Same setup, dgsclt=1, mdfy=1 -> dg_ps_add=0x0104, dg_dm_add=0, I2 remains 0x0100.
REQ-037 B1=0x0200 (I1 side-loads 0x0200), L1=0x0008, M0=0x0003, post-modify on iadd=1 three times -> addresses 0x0200, 0x0203, 0x0206; I1 ends 0x0201.
REQ-038 B1=0x0200, L1=8, I1=0x0201, M0=0xFFFE (-2), post-modify -> address 0x0201, I1 becomes 0x0207.
REQ-039 Same cycle: write I4=0x0050 via ureg and post-modify request on I4 with M=1 -> address 0x0050 (forwarded), I4 becomes 0x0050 (write wins); read of I4 that cycle returns 0x0050.
REQ-040 Assert rst low mid-cycle with I2=0x1234 and post-modify pending -> all registers 0 immediately, no update after release.
